// File: rtl/approx_mult_pipe_if.sv
// approx_mult_pipe_if: operand/result handshake bundle for approx_mult_pipe
interface approx_mult_pipe_if #(parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           in_exact;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_z;
  logic           busy;
  modport master (
    output in_valid, in_x, in_y, in_exact, out_ready,
    input  in_ready, out_valid, out_z, busy
  );
  modport slave (
    input  in_valid, in_x, in_y, in_exact, out_ready,
    output in_ready, out_valid, out_z, busy
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: elastic pipelined unsigned row-truncated approximate multiplier (W x W -> 2W).
// Defining APPROX_BIAS_EN adds a saturating 1<<(W-2) bias in approximate mode.
module approx_mult_pipe #(
  parameter int W      = 8,
  parameter int L      = 4,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  approx_mult_pipe_if.slave io
);
  localparam int ZW = 2 * W;
  logic [ZW-1:0]     w_exact, w_h, w_a, w_z;
  logic [STAGES-1:0] w_adv, r_v;
  logic [ZW-1:0]     r_z [STAGES];
  always_comb begin
    w_exact = {{W{1'b0}}, io.in_x} * {{W{1'b0}}, io.in_y};
    w_h = ({{W{1'b0}}, io.in_y} * {{(W+L){1'b0}}, io.in_x[W-1:L]}) << L;
    w_a = '0;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < W; j++)
        if (i + j >= W - 1 && io.in_x[i] && io.in_y[j]) w_a = w_a + (ZW'(1) << (i + j));
  end
`ifdef APPROX_BIAS_EN
  logic [ZW:0] w_sum;
  always_comb begin
    w_sum = {1'b0, w_h} + {1'b0, w_a} +
            ((|io.in_x[L-1:0] && |io.in_y) ? ((ZW+1)'(1) << (W - 2)) : {(ZW+1){1'b0}});
    w_z = io.in_exact ? w_exact : (w_sum[ZW] ? {ZW{1'b1}} : w_sum[ZW-1:0]);
  end
`else
  assign w_z = io.in_exact ? w_exact : w_h + w_a;
`endif
  // a stage may move when any stage at or beyond it is empty, or the consumer takes the last one
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign w_adv[k] = io.out_ready | ~&r_v[STAGES-1:k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) r_z[k] <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0] <= io.in_valid;
        if (io.in_valid) r_z[0] <= w_z;
      end
      for (int k = 1; k < STAGES; k++)
        if (w_adv[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) r_z[k] <= r_z[k-1];
        end
    end
  end
  assign io.in_ready  = w_adv[0];
  assign io.out_valid = r_v[STAGES-1];
  assign io.out_z     = r_z[STAGES-1];
  assign io.busy      = |r_v;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed and randomised checks of approx_mult_pipe (W=8, L=4, STAGES=2, no bias)
module tb_approx_mult_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;
  int          n_del = 0;
  logic [15:0] q[$];
  logic [7:0]  px, py;
  logic        pe;
  logic        g_acc, g_del;
  approx_mult_pipe_if #(.W(8)) io();
  approx_mult_pipe #(.W(8), .L(4), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  // reference: full product minus the low-row partial products below column W-1
  function automatic logic [15:0] ref_z(input logic [7:0] x, input logic [7:0] y, input logic e);
    logic [15:0] p, drop;
    p = 16'(x) * 16'(y);
    drop = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        if (i + j < 7 && x[i] && y[j]) drop = drop + (16'(1) << (i + j));
    return e ? p : p - drop;
  endfunction
  task automatic new_op();
    px = 8'($urandom);
    py = 8'($urandom);
    pe = 1'($urandom_range(0, 1));
  endtask
  task automatic cyc(input logic v, input logic r);
    @(negedge clk);
    io.in_valid = v; io.in_x = px; io.in_y = py; io.in_exact = pe; io.out_ready = r;
    #1;
    g_acc = io.in_valid && io.in_ready;
    g_del = io.out_valid && io.out_ready;
    if (g_acc) q.push_back(ref_z(px, py, pe));
    if (g_del) begin
      n_del++;
      if (q.size() == 0) chk("spurious", 32'(io.out_valid), 0);
      else chk("data", 32'(io.out_z), 32'(q.pop_front()));
    end
  endtask
  task automatic single(input logic [7:0] x, input logic [7:0] y, input logic e, input logic [15:0] exp);
    @(negedge clk);
    io.in_valid = 1'b1; io.in_x = x; io.in_y = y; io.in_exact = e; io.out_ready = 1'b1;
    #1 chk("vec_in_ready", 32'(io.in_ready), 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("vec_lat1_valid", 32'(io.out_valid), 0);
    chk("vec_lat1_busy", 32'(io.busy), 1);
    @(negedge clk);
    chk("vec_lat2_valid", 32'(io.out_valid), 1);
    chk("vec_z", 32'(io.out_z), 32'(exp));
  endtask
  logic [7:0]  vx [6] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h10, 8'h80};
  logic [7:0]  vy [6] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h0A, 8'h80};
  logic        ve [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] vz [6] = '{16'd64528, 16'd65025, 16'd0, 16'd225, 16'd160, 16'd16384};
  initial begin
    int n0, na, sent, cycles;
    logic [15:0] z_hold;
    rst_n = 1'b0;
    io.in_valid = 1'b0; io.in_x = '0; io.in_y = '0; io.in_exact = 1'b0; io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(io.out_valid), 0);
    chk("rst_out_z", 32'(io.out_z), 0);
    chk("rst_busy", 32'(io.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 1);
    for (int i = 0; i < 6; i++) single(vx[i], vy[i], ve[i], vz[i]);
    @(negedge clk);
    chk("idle_busy", 32'(io.busy), 0);
    // 16 back-to-back ops must come out on 16 consecutive cycles
    new_op();
    n0 = n_del;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1);
      chk("stream_acc", 32'(g_acc), 1);
      new_op();
    end
    repeat (2) cyc(1'b0, 1'b1);
    chk("stream_cnt", 32'(n_del - n0), 16);
    chk("stream_empty", 32'(q.size()), 0);
    na = 0;
    z_hold = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      if (g_acc) begin na++; new_op(); end
      if (i == 2) z_hold = io.out_z;
      if (i == 4) chk("bp_hold_z", 32'(io.out_z), 32'(z_hold));
    end
    chk("bp_acc", 32'(na), 2);
    chk("bp_in_ready", 32'(io.in_ready), 0);
    chk("bp_out_valid", 32'(io.out_valid), 1);
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    chk("bp_drain", 32'(q.size()), 0);
    new_op();
    sent = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 60000) begin
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7));
      if (g_acc) begin sent++; new_op(); end
      cycles++;
    end
    chk("rand_sent", 32'(sent), 10000);
    for (int i = 0; i < 50 && q.size() > 0; i++) cyc(1'b0, 1'b1);
    chk("rand_drain", 32'(q.size()), 0);
    // asynchronous reset with two ops in flight
    new_op(); cyc(1'b1, 1'b0);
    new_op(); cyc(1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(io.out_valid), 0);
    chk("arst_busy", 32'(io.busy), 0);
    chk("arst_out_z", 32'(io.out_z), 0);
    q.delete();
    io.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1);
      chk("arst_no_stale", 32'(io.out_valid), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
